// File: rtl/getin_feeder_if.sv
// Host push handshake and processor getin port of the getin feeder.
interface getin_feeder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] host_data;
  logic             host_valid;
  logic             host_ready;
  logic [WIDTH-1:0] getin;
  logic             in_req;
  logic             in_stall;

  modport slave (
    input  host_data, host_valid, in_req,
    output host_ready, getin, in_stall
  );

  modport master (
    output host_data, host_valid, in_req,
    input  host_ready, getin, in_stall
  );
endinterface

// File: rtl/getin_feeder.sv
// Host-fed FIFO driving the processor getin port; stalls the core on empty reads.
// Define GETIN_BYPASS_EN for cut-through of a host word straight to getin when empty.
module getin_feeder #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  getin_feeder_if.slave          bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             empty;
  logic             full;
  logic             bypass;
  logic             push;
  logic             pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

`ifdef GETIN_BYPASS_EN
  assign bypass = reset && empty && bus.in_req && bus.host_valid;
`else
  assign bypass = 1'b0;
`endif

  assign bus.host_ready = reset && !full;
  assign bus.in_stall   = reset && bus.in_req && empty && !bypass;

  // A bypassed word goes straight to the core and never touches the array.
  assign push = bus.host_valid && bus.host_ready && !bypass;
  assign pop  = bus.in_req && !bus.in_stall && !empty;

  always_comb begin
    bus.getin = '0;
    if (!empty)
      bus.getin = mem[rp];
    else if (bypass)
      bus.getin = bus.host_data;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wp] <= bus.host_data;
  end
endmodule

// File: tb/tb_getin_feeder.sv
// Directed self-checking bench for getin_feeder (DEPTH=8, WIDTH=16).
module tb_getin_feeder;
  logic       CLK;
  logic       reset;
  logic [3:0] count;
  int         checks;
  int         failures;

  getin_feeder_if #(.WIDTH(16)) bus ();

  getin_feeder #(.DEPTH(8), .WIDTH(16)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave),
    .count (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    bus.host_valid = 1'b0;
    bus.host_data  = '0;
    bus.in_req     = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (bus.getin !== 16'h0000) begin failures++; $display("FAIL rst_getin got=%h exp=0000", bus.getin); end
    checks++; if (bus.host_ready !== 1'b0) begin failures++; $display("FAIL rst_host_ready got=%b exp=0", bus.host_ready); end
    checks++; if (bus.in_stall !== 1'b0) begin failures++; $display("FAIL rst_in_stall got=%b exp=0", bus.in_stall); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (bus.host_ready !== 1'b1) begin failures++; $display("FAIL idle_host_ready got=%b exp=1", bus.host_ready); end
    checks++; if (bus.in_stall !== 1'b0) begin failures++; $display("FAIL idle_in_stall got=%b exp=0", bus.in_stall); end
    bus.in_req = 1'b1;
    #1;
    checks++; if (bus.in_stall !== 1'b1) begin failures++; $display("FAIL empty_stall got=%b exp=1", bus.in_stall); end
    tick();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL empty_req_count got=%0d exp=0", count); end
    checks++; if (bus.in_stall !== 1'b1) begin failures++; $display("FAIL empty_stall_held got=%b exp=1", bus.in_stall); end
    bus.in_req = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [15:0] words [3];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    tick();
    bus.host_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.host_data = words[i];
      tick();
    end
    bus.host_valid = 1'b0;
    #1;
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL pp_count got=%0d exp=3", count); end
    bus.in_req = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.getin !== words[i]) begin failures++; $display("FAIL pp_getin[%0d] got=%h exp=%h", i, bus.getin, words[i]); end
      checks++; if (bus.in_stall !== 1'b0) begin failures++; $display("FAIL pp_stall[%0d] got=%b exp=0", i, bus.in_stall); end
      checks++; if (count !== 4'(3 - i)) begin failures++; $display("FAIL pp_cnt[%0d] got=%0d exp=%0d", i, count, 3 - i); end
      tick();
    end
    bus.in_req = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL pp_end_count got=%0d exp=0", count); end
    checks++; if (bus.getin !== 16'h0000) begin failures++; $display("FAIL pp_end_getin got=%h exp=0000", bus.getin); end
  endtask

  task automatic test_full();
    logic [15:0] exp;
    bus.host_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.host_data = 16'hA000 + 16'(i);
      tick();
    end
    #1;
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", count); end
    checks++; if (bus.host_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", bus.host_ready); end
    bus.host_data = 16'hBEEF;
    bus.in_req    = 1'b1;
    #1;
    checks++; if (bus.getin !== 16'hA000) begin failures++; $display("FAIL full_head got=%h exp=A000", bus.getin); end
    tick();
    bus.in_req = 1'b0;
    #1;
    checks++; if (count !== 4'd7) begin failures++; $display("FAIL full_pop_count got=%0d exp=7", count); end
    checks++; if (bus.host_ready !== 1'b1) begin failures++; $display("FAIL full_pop_ready got=%b exp=1", bus.host_ready); end
    tick();
    bus.host_valid = 1'b0;
    #1;
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_beef_count got=%0d exp=8", count); end
    bus.in_req = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      exp = (i == 7) ? 16'hBEEF : 16'hA001 + 16'(i);
      checks++; if (bus.getin !== exp) begin failures++; $display("FAIL drain[%0d] got=%h exp=%h", i, bus.getin, exp); end
      tick();
    end
    bus.in_req = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_stall_push();
    bus.in_req = 1'b1;
    #1;
    checks++; if (bus.in_stall !== 1'b1) begin failures++; $display("FAIL sp_pre_stall got=%b exp=1", bus.in_stall); end
    tick();
    bus.host_valid = 1'b1;
    bus.host_data  = 16'h5A5A;
    #1;
`ifdef GETIN_BYPASS_EN
    checks++; if (bus.in_stall !== 1'b0) begin failures++; $display("FAIL byp_stall got=%b exp=0", bus.in_stall); end
    checks++; if (bus.getin !== 16'h5A5A) begin failures++; $display("FAIL byp_getin got=%h exp=5A5A", bus.getin); end
    checks++; if (bus.host_ready !== 1'b1) begin failures++; $display("FAIL byp_ready got=%b exp=1", bus.host_ready); end
    tick();
    bus.host_valid = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL byp_count got=%0d exp=0", count); end
    checks++; if (bus.in_stall !== 1'b1) begin failures++; $display("FAIL byp_after_stall got=%b exp=1", bus.in_stall); end
`else
    checks++; if (bus.in_stall !== 1'b1) begin failures++; $display("FAIL sp_edge_stall got=%b exp=1", bus.in_stall); end
    checks++; if (bus.getin !== 16'h0000) begin failures++; $display("FAIL sp_edge_getin got=%h exp=0000", bus.getin); end
    tick();
    bus.host_valid = 1'b0;
    #1;
    checks++; if (bus.in_stall !== 1'b0) begin failures++; $display("FAIL sp_n1_stall got=%b exp=0", bus.in_stall); end
    checks++; if (bus.getin !== 16'h5A5A) begin failures++; $display("FAIL sp_n1_getin got=%h exp=5A5A", bus.getin); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL sp_n1_count got=%0d exp=1", count); end
    tick();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL sp_pop_count got=%0d exp=0", count); end
    checks++; if (bus.in_stall !== 1'b1) begin failures++; $display("FAIL sp_pop_stall got=%b exp=1", bus.in_stall); end
`endif
    bus.in_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.host_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.host_data = 16'hC000 + 16'(i);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      bus.host_data = 16'hC004 + 16'(i);
      bus.in_req    = 1'b1;
      #1;
      checks++; if (bus.getin !== 16'hC000 + 16'(i)) begin failures++; $display("FAIL b2b_getin[%0d] got=%h exp=%h", i, bus.getin, 16'hC000 + 16'(i)); end
      checks++; if (count !== 4'd4) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=4", i, count); end
      tick();
    end
    bus.in_req    = 1'b0;
    bus.host_data = 16'hC00E;
    tick();
    bus.host_valid = 1'b0;
    #1;
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL b2b_end_count got=%0d exp=5", count); end
    checks++; if (bus.getin !== 16'hC00A) begin failures++; $display("FAIL b2b_end_getin got=%h exp=C00A", bus.getin); end
  endtask

  task automatic test_async_reset();
    bus.in_req = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", count); end
    checks++; if (bus.getin !== 16'h0000) begin failures++; $display("FAIL ar_getin got=%h exp=0000", bus.getin); end
    checks++; if (bus.host_ready !== 1'b0) begin failures++; $display("FAIL ar_ready got=%b exp=0", bus.host_ready); end
    checks++; if (bus.in_stall !== 1'b0) begin failures++; $display("FAIL ar_stall got=%b exp=0", bus.in_stall); end
    tick();
    bus.in_req = 1'b0;
    reset = 1'b1;
    bus.host_valid = 1'b1;
    bus.host_data  = 16'h0042;
    tick();
    bus.host_valid = 1'b0;
    #1;
    checks++; if (bus.getin !== 16'h0042) begin failures++; $display("FAIL ar_new_getin got=%h exp=0042", bus.getin); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL ar_new_count got=%0d exp=1", count); end
    bus.in_req = 1'b1;
    tick();
    bus.in_req = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL ar_final_count got=%0d exp=0", count); end
    checks++; if (bus.getin !== 16'h0000) begin failures++; $display("FAIL ar_stale_getin got=%h exp=0000", bus.getin); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_push_pop();
    test_full();
    test_stall_push();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
